// File: rtl/truth_table_probe.sv
// truth_table_probe: sweeps all eight input rows of a 3-input gate, samples
// its output three times per row, and rebuilds the 8-bit truth-table
// identifier (bit 7-r = output for row r = {in1,in2,in3}). A majority vote
// picks each bit, and any row whose samples disagree sets a sticky glitch flag.
module truth_table_probe #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected_tt,
    output logic       probe_in1,
    output logic       probe_in2,
    output logic       probe_in3,
    input  logic       probe_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       match,
    output logic       glitch
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nxt;

    // sync_pipe[1] is the synchronized gate output; everything samples it
    logic [1:0] sync_pipe;
    logic [7:0] settle_cnt;
    logic [1:0] smp_idx;
    logic       s0;
    logic       s1;
    logic [2:0] row;
    logic [2:0] probe;
    logic [7:0] exp_q;

    logic       maj;
    logic       row_glitch;
    logic [7:0] tt_nxt;
    logic       glitch_nxt;

    // The gate output may be asynchronous to clk: two-flop synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pipe <= 2'b00;
        end else begin
            sync_pipe <= {sync_pipe[0], probe_out};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: settle, take three samples, advance row or finish
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
            SAMPLE:  if (smp_idx == 2'd2) state_nxt = (row == 3'd7) ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        busy = (state == SETTLE) || (state == SAMPLE);
        done = (state == DONE);
    end

    // Third-sample evaluation: vote, disagreement check, and the updated tt
    always_comb begin
        maj        = (s0 & s1) | (s0 & sync_pipe[1]) | (s1 & sync_pipe[1]);
        row_glitch = !((s0 == s1) && (s1 == sync_pipe[1]));
        glitch_nxt = glitch | row_glitch;
        tt_nxt     = tt;
        tt_nxt[3'd7 - row] = maj;
    end

    // Sweep datapath: row/probe sequencing, sample capture, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 8'd0;
            smp_idx    <= 2'd0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            row        <= 3'd0;
            probe      <= 3'd0;
            exp_q      <= 8'h00;
            tt         <= 8'h00;
            glitch     <= 1'b0;
            match      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row        <= 3'd0;
                        probe      <= 3'd0;
                        tt         <= 8'h00;
                        glitch     <= 1'b0;
                        match      <= 1'b0;
                        exp_q      <= expected_tt;
                        settle_cnt <= 8'd1;
                        smp_idx    <= 2'd0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    smp_idx    <= 2'd0;
                end
                SAMPLE: begin
                    smp_idx <= smp_idx + 2'd1;
                    case (smp_idx)
                        2'd0: s0 <= sync_pipe[1];
                        2'd1: s1 <= sync_pipe[1];
                        default: begin
                            tt     <= tt_nxt;
                            glitch <= glitch_nxt;
                            if (row != 3'd7) begin
                                row        <= row + 3'd1;
                                probe      <= row + 3'd1;
                                settle_cnt <= 8'd1;
                            end else begin
                                // Last row: result becomes visible with done
                                probe <= 3'd0;
                                match <= (tt_nxt == exp_q) && !glitch_nxt;
                            end
                        end
                    endcase
                end
                default: begin
                    probe <= 3'd0;
                end
            endcase
        end
    end

    assign probe_in1 = probe[2];
    assign probe_in2 = probe[1];
    assign probe_in3 = probe[0];

endmodule

// File: tb/tb_truth_table_probe.sv
// Bench for truth_table_probe: a behavioural gate drives probe_out, optional
// one-cycle output inversions emulate glitches, and a row/sample model derives
// the expected identifier, glitch and match for every sweep.
module tb_truth_table_probe;

    localparam int S     = 4;
    localparam int ROW   = S + 3;
    localparam int SWEEP = 8 * ROW;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] expected_tt;
    logic       probe_in1, probe_in2, probe_in3;
    logic       probe_out;
    logic       busy, done, match, glitch;
    logic [7:0] tt;

    logic [7:0] gate_tt;
    logic       flip;
    logic [2:0] probe_row;

    int n_checks = 0;
    int n_fail   = 0;

    truth_table_probe #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .expected_tt (expected_tt),
        .probe_in1   (probe_in1),
        .probe_in2   (probe_in2),
        .probe_in3   (probe_in3),
        .probe_out   (probe_out),
        .busy        (busy),
        .done        (done),
        .tt          (tt),
        .match       (match),
        .glitch      (glitch)
    );

    always #5 clk = ~clk;

    assign probe_row = {probe_in1, probe_in2, probe_in3};
    assign probe_out = gate_tt[3'd7 - probe_row] ^ flip;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected result: each row's output bit, seen through the inversion mask
    // at the three sample edges (an inversion across edge j shows up in the
    // synchronized sample taken at edge j+2), reduced by majority vote.
    task automatic model(input logic [7:0] g, input logic [0:63] m,
                         output logic [7:0] t, output logic gl);
        t  = 8'h00;
        gl = 1'b0;
        for (int r = 0; r < 8; r++) begin
            int ones = 0;
            for (int i = 0; i < 3; i++) begin
                int e = r * ROW + S + 1 + i;
                ones += int'(g[7 - r] ^ m[e - 2]);
            end
            t[7 - r] = (ones >= 2);
            if (ones != 0 && ones != 3) gl = 1'b1;
        end
    endtask

    // One sweep from the current negedge: start is accepted at the next edge (E0).
    // Cycle k is the cycle after edge E0+k. abort_at >= 0 pulls rst mid-sweep.
    task automatic run_sweep(input logic [7:0] g, input logic [7:0] ex,
                             input logic [0:63] m, input bit repulse, input int abort_at);
        logic [7:0] t_exp;
        logic       gl_exp;
        logic       m_exp;
        model(g, m, t_exp, gl_exp);
        m_exp       = (t_exp == ex) && !gl_exp;
        gate_tt     = g;
        expected_tt = ex;
        start       = 1'b1;
        flip        = m[0];
        for (int k = 0; k <= SWEEP + 1; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_probe", 32'(probe_row), 0);
                chk("abort_tt", 32'(tt), 0);
                chk("abort_match", 32'(match), 0);
                chk("abort_glitch", 32'(glitch), 0);
                start = 1'b0;
                flip  = 1'b0;
                @(negedge clk);
                chk("abort_nodone", 32'(done), 0);
                rst = 1'b0;
                return;
            end
            start = repulse && (k + 1 == 10 || k + 1 == 30);
            flip  = m[k + 1];
            if (k == 0) begin
                chk("clr_tt", 32'(tt), 0);
                chk("clr_glitch", 32'(glitch), 0);
                chk("clr_match", 32'(match), 0);
            end
            if (k < SWEEP) begin
                chk("busy", 32'(busy), 1);
                chk("done_early", 32'(done), 0);
                chk("probe_row", 32'(probe_row), 32'(k / ROW));
            end else if (k == SWEEP) begin
                chk("done", 32'(done), 1);
                chk("busy_done", 32'(busy), 0);
                chk("tt", 32'(tt), 32'(t_exp));
                chk("match", 32'(match), 32'(m_exp));
                chk("glitch", 32'(glitch), 32'(gl_exp));
                chk("probe_home", 32'(probe_row), 0);
            end else begin
                chk("done_once", 32'(done), 0);
                chk("busy_idle", 32'(busy), 0);
                chk("tt_hold", 32'(tt), 32'(t_exp));
                chk("match_hold", 32'(match), 32'(m_exp));
            end
        end
    endtask

    logic [0:63] mask;
    logic [7:0]  rg, rex;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        expected_tt = 8'h00;
        gate_tt     = 8'h00;
        flip        = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tt", 32'(tt), 0);
        chk("rst_match", 32'(match), 0);
        chk("rst_glitch", 32'(glitch), 0);
        chk("rst_probe", 32'(probe_row), 0);
        rst = 1'b0;
        @(negedge clk);

        mask = '0;
        run_sweep(8'hD7, 8'hD7, mask, 1'b0, -1);
        run_sweep(8'hAA, 8'hD7, mask, 1'b0, -1);
        run_sweep(8'h00, 8'h00, mask, 1'b0, -1);
        run_sweep(8'hFF, 8'hFF, mask, 1'b0, -1);

        // Single inverted synchronized sample: s1 of row 010
        mask = '0;
        mask[18] = 1'b1;
        run_sweep(8'hD7, 8'hD7, mask, 1'b0, -1);

        // Start re-pulsed mid-sweep, then a back-to-back sweep at done+1
        mask = '0;
        run_sweep(8'hD7, 8'hD7, mask, 1'b1, -1);
        run_sweep(8'h3C, 8'h3C, mask, 1'b0, -1);

        // Reset mid-row 2, then a clean sweep right after release
        run_sweep(8'hD7, 8'hD7, mask, 1'b0, 20);
        run_sweep(8'h96, 8'h96, mask, 1'b0, -1);

        // Random gates, expectations and inversion points
        for (int n = 0; n < 12; n++) begin
            rg   = 8'($urandom);
            rex  = ($urandom_range(0, 1) == 1) ? rg : 8'($urandom);
            mask = '0;
            for (int f = 0; f < int'($urandom_range(0, 2)); f++)
                mask[$urandom_range(1, SWEEP - 1)] = 1'b1;
            run_sweep(rg, rex, mask, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
